// File: rtl/pooled_serializer.sv
// Captures pooled-pixel bundles into a two-deep buffer and streams them lane 0 first, one beat per cycle; first beat valid one cycle after En.
// Beats hold stable while pixelReady is low; a bundle arriving with both slots held and no release that cycle is dropped and overflow sticks.
module pooled_serializer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          En,
  input  logic [LANES-1:0][DATA_W-1:0]  pooledPixels,
  output logic [DATA_W-1:0]             pixelOut,
  output logic                          pixelValid,
  input  logic                          pixelReady,
  output logic                          pixelLast,
  output logic [1:0]                    occupancy,
  output logic                          overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occState_t;

  typedef logic [LANES-1:0][DATA_W-1:0] bundle_t;

  occState_t         state;
  occState_t         stateNext;
  logic [LANE_W-1:0] lane;
  bundle_t           headQ;
  bundle_t           tailQ;
  logic              overflowQ;

  logic beatXfer;
  logic lastXfer;
  logic loadHeadNew;
  logic loadHeadTail;
  logic loadTailNew;
  logic dropBundle;

  assign beatXfer = (state != EMPTY) && pixelReady;
  assign lastXfer = beatXfer && (lane == LAST_LANE);

  // Slot steering: a release in the same cycle as a capture shifts the queue
  // so the new bundle always lands behind whatever is still pending.
  assign loadHeadNew  = En && ((state == EMPTY) || (state == ONE && lastXfer));
  assign loadHeadTail = (state == TWO) && lastXfer;
  assign loadTailNew  = En && ((state == ONE && !lastXfer) || (state == TWO && lastXfer));
  assign dropBundle   = En && (state == TWO) && !lastXfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      EMPTY: begin
        if (En) stateNext = ONE;
      end
      ONE: begin
        if (En && !lastXfer)      stateNext = TWO;
        else if (!En && lastXfer) stateNext = EMPTY;
      end
      TWO: begin
        if (lastXfer && !En) stateNext = ONE;
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_comb begin
    pixelValid = (state != EMPTY);
    pixelOut   = headQ[lane];
    pixelLast  = (state != EMPTY) && (lane == LAST_LANE);
    occupancy  = state;
    overflow   = overflowQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= '0;
      headQ     <= '0;
      tailQ     <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (lastXfer) begin
        lane <= '0;
      end else if (beatXfer) begin
        lane <= lane + 1'b1;
      end

      if (loadHeadNew) begin
        headQ <= pooledPixels;
      end else if (loadHeadTail) begin
        headQ <= tailQ;
      end

      if (loadTailNew) begin
        tailQ <= pooledPixels;
      end

      if (dropBundle) begin
        overflowQ <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pooled_serializer.sv
// Directed vector bench for pooled_serializer: each record drives one cycle of inputs and
// lists the outputs expected just before that cycle's clock edge.
module tb_pooled_serializer;

  logic             clk;
  logic             rst;
  logic             En;
  logic [3:0][7:0]  pooledPixels;
  logic [7:0]       pixelOut;
  logic             pixelValid;
  logic             pixelReady;
  logic             pixelLast;
  logic [1:0]       occupancy;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  pooled_serializer #(.DATA_W(8), .LANES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .En           (En),
    .pooledPixels (pooledPixels),
    .pixelOut     (pixelOut),
    .pixelValid   (pixelValid),
    .pixelReady   (pixelReady),
    .pixelLast    (pixelLast),
    .occupancy    (occupancy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        e;
    logic [31:0] pix;
    logic        rdy;
    logic        chk;
    logic        v;
    logic [7:0]  o;
    logic        l;
    logic [1:0]  occ;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [31:0] pix, logic rdy, logic chk,
                              logic v, logic [7:0] o, logic l, logic [1:0] occ, logic ovf);
    vec_t t;
    t.r = r; t.e = e; t.pix = pix; t.rdy = rdy; t.chk = chk;
    t.v = v; t.o = o; t.l = l; t.occ = occ; t.ovf = ovf;
    return t;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the registered outputs.
  task automatic applyVec(vec_t t, string tag);
    @(negedge clk);
    rst          = t.r;
    En           = t.e;
    pooledPixels = t.pix;
    pixelReady   = t.rdy;
    #1;
    if (t.chk) begin
      cmp({tag, " pixelValid"}, {31'd0, pixelValid}, {31'd0, t.v});
      cmp({tag, " pixelOut"},   {24'd0, pixelOut},   {24'd0, t.o});
      cmp({tag, " pixelLast"},  {31'd0, pixelLast},  {31'd0, t.l});
      cmp({tag, " occupancy"},  {30'd0, occupancy},  {30'd0, t.occ});
      cmp({tag, " overflow"},   {31'd0, overflow},   {31'd0, t.ovf});
    end
  endtask

  localparam logic [31:0] BS = 32'hfc333832;
  localparam logic [31:0] BA = 32'h04030201;
  localparam logic [31:0] BB = 32'h08070605;
  localparam logic [31:0] BC = 32'h44332211;
  localparam logic [31:0] BD = 32'ha4a3a2a1;
  localparam logic [31:0] BE = 32'hb4b3b2b1;
  localparam logic [31:0] BF = 32'hc4c3c2c1;
  localparam logic [31:0] BG = 32'hd4d3d2d1;
  localparam logic [31:0] BH = 32'he4e3e2e1;
  localparam logic [31:0] BI = 32'hf4f3f2f1;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; En = 1'b0; pooledPixels = '0; pixelReady = 1'b0;

    //                 r  e  pix  rdy chk v  out    l  occ ovf
    // reset and idle
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'h00, 0, 0, 0));
    // single bundle
    tbl.push_back(mk(0, 1, BS, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h32, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h38, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h33, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'hfc, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'h32, 0, 0, 0));
    // back-to-back at pooling cadence; B lands on A's last beat
    tbl.push_back(mk(0, 1, BA, 1, 1, 0, 8'h32, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h02, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h03, 0, 1, 0));
    tbl.push_back(mk(0, 1, BB, 1, 1, 1, 8'h04, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h05, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h06, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h07, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h08, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'h05, 0, 0, 0));
    // backpressure at lane 1
    tbl.push_back(mk(0, 1, BC, 1, 1, 0, 8'h05, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h11, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0, 1, 1, 8'h22, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0, 1, 1, 8'h22, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0, 1, 1, 8'h22, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h22, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h33, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'h44, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'h11, 0, 0, 0));
    // overflow: three bundles while stalled, third dropped
    tbl.push_back(mk(0, 1, BD, 0, 1, 0, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 1, BE, 0, 1, 1, 8'ha1, 0, 1, 0));
    tbl.push_back(mk(0, 1, BF, 0, 1, 1, 8'ha1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0,  0, 1, 1, 8'ha1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'ha1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'ha2, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'ha3, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'ha4, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'hb1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'hb2, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'hb3, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 1, 8'hb4, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0,  1, 1, 0, 8'hb1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyVec(tbl[i], $sformatf("vec%0d", i));
    end

    // Capture coincident with last beat at occupancy 2: accepted, nothing dropped.
    applyVec(mk(1, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0), "sim_rst");
    applyVec(mk(0, 0, 0,  0, 1, 0, 8'h00, 0, 0, 0), "sim_clear");
    applyVec(mk(0, 1, BG, 0, 1, 0, 8'h00, 0, 0, 0), "sim_g");
    applyVec(mk(0, 1, BH, 0, 1, 1, 8'hd1, 0, 1, 0), "sim_h");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hd1, 0, 2, 0), "sim_d1");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hd2, 0, 2, 0), "sim_d2");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hd3, 0, 2, 0), "sim_d3");
    applyVec(mk(0, 1, BI, 1, 1, 1, 8'hd4, 1, 2, 0), "sim_d4_en");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'he1, 0, 2, 0), "sim_e1");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'he2, 0, 2, 0), "sim_e2");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'he3, 0, 2, 0), "sim_e3");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'he4, 1, 2, 0), "sim_e4");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hf1, 0, 1, 0), "sim_f1");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hf2, 0, 1, 0), "sim_f2");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hf3, 0, 1, 0), "sim_f3");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'hf4, 1, 1, 0), "sim_f4");
    applyVec(mk(0, 0, 0,  1, 1, 0, 8'hf1, 0, 0, 0), "sim_idle");

    // Reset at lane 2 of A with B queued, En alongside rst ignored, then a fresh bundle.
    applyVec(mk(0, 1, BA, 1, 1, 0, 8'hf1, 0, 0, 0), "mid_a");
    applyVec(mk(0, 1, BB, 1, 1, 1, 8'h01, 0, 1, 0), "mid_b");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'h02, 0, 2, 0), "mid_l1");
    applyVec(mk(1, 1, BC, 1, 1, 1, 8'h03, 0, 2, 0), "mid_rst");
    applyVec(mk(0, 0, 0,  1, 1, 0, 8'h00, 0, 0, 0), "mid_after");
    applyVec(mk(0, 1, BC, 1, 1, 0, 8'h00, 0, 0, 0), "mid_c");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'h11, 0, 1, 0), "mid_c0");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'h22, 0, 1, 0), "mid_c1");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'h33, 0, 1, 0), "mid_c2");
    applyVec(mk(0, 0, 0,  1, 1, 1, 8'h44, 1, 1, 0), "mid_c3");
    applyVec(mk(0, 0, 0,  1, 1, 0, 8'h11, 0, 0, 0), "mid_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pooled_serializer.md
# pooled_serializer

Consumer-side companion to the pooling stage. It captures a full bundle of pooled pixels each time the pooling stage strobes `En`, then streams the pixels out one per beat, lane 0 first, over a valid/ready handshake to the downstream buffer or writer. A two-entry bundle buffer lets the pooling stage run ahead of a stalled consumer by one window. Bundles arriving when the buffer is full are dropped and flagged.

## Interface
Parameters:
- `DATA_W`, 8, pixel width in bits
- `LANES`, 4, pixels per pooled bundle (must be ≥ 2)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `En`  in  1  bundle strobe from pooling stage, one-cycle pulse, sampled at posedge
- `pooledPixels`  in  [LANES-1:0][DATA_W-1:0]  bundle, valid only in a cycle with `En`=1
- `pixelOut`  out  DATA_W  current output pixel
- `pixelValid`  out  1  `pixelOut` holds a valid beat
- `pixelReady`  in  1  downstream accepts the beat
- `pixelLast`  out  1  current beat is lane LANES-1 of its bundle
- `occupancy`  out  2  bundles held, 0..2
- `overflow`  out  1  sticky: a bundle was dropped

## Operation
- Storage: two bundle registers (head, tail), an occupancy count (0..2), and a lane index (0..LANES-1) into head.
- Beat handshake: a beat transfers at a posedge with `pixelValid && pixelReady`.
- `pixelValid` = (occupancy ≠ 0).
- `pixelOut` = head[lane]. It is a mux from registers only, with no combinational path from `pooledPixels` or `En`.
- `pixelLast` = `pixelValid && lane == LANES-1`.
- On a transfer with lane < LANES-1: lane increments.
- On a transfer with lane = LANES-1: lane returns to 0, head is released, tail (if held) becomes head, and occupancy decrements.
- Capture on `En`=1: the bundle is written to the first free slot (head if occupancy 0, else tail), and occupancy increments.
- Simultaneous capture and last-beat release in one cycle:
  - Net occupancy is unchanged.
  - With occupancy 1, the new bundle becomes head directly.
  - With occupancy 2, the old tail becomes head and the new bundle becomes tail.
  - Nothing is dropped in either case.
- Overflow: `En`=1 with occupancy 2 and no last-beat release that cycle.
  - The bundle is discarded and `overflow` is set.
  - `overflow` stays set until `rst`.
  - Buffer contents and lane are untouched.
- Stall: while `pixelValid && !pixelReady`, `pixelOut`, `pixelLast` and lane hold stable.
- Occupancy encodes three states (EMPTY/ONE/TWO), crossed with the lane counter. No other FSM is used.

## Timing
- Reset values: `pixelValid`=0, `pixelOut`=0, `pixelLast`=0, `occupancy`=0, `overflow`=0, lane=0, and both bundle registers 0.
- `rst` mid-stream discards all held bundles and any partially sent bundle at the next posedge. `En` in the same cycle as `rst` is ignored.
- Latency: `En` at posedge k into an empty buffer gives `pixelValid`=1 with lane 0 in the cycle after edge k.
- Throughput: with `pixelReady` held at 1, LANES beats per bundle and no bubbles between back-to-back bundles.
- Pooling cadence of one `En` every LANES cycles is sustained indefinitely with `pixelReady`=1.
- `pixelReady` may toggle freely. The block never drops or repeats a beat.
- `pixelValid` never deasserts before a transfer completes.

## Test plan
- **Reset and idle.** Assert `rst` 2 cycles, no `En` → all outputs 0, `pixelValid` never rises.
- **Single bundle.** `pooledPixels`={8'hfc,8'h33,8'h38,8'h32} (lane3..0), `En` one cycle, `pixelReady`=1 → beats 8'h32, 8'h38, 8'h33, 8'hfc on 4 consecutive cycles starting the cycle after `En`, `pixelLast` only on 8'hfc, then `pixelValid`=0.
- **Back-to-back at pooling cadence.** Bundle A = {8'h04,8'h03,8'h02,8'h01}, then bundle B = {8'h08,8'h07,8'h06,8'h05} via `En` every 4 cycles → continuous stream 01..08 with no bubble, `occupancy` never exceeds 1, `overflow`=0.
- **Backpressure.** `pixelReady`=0 for 3 cycles mid-bundle at lane 1 → `pixelOut` holds the lane-1 value stably, and the stream resumes at lane 1 with no duplicates.
- **Overflow and simultaneous release.**
  - Hold `pixelReady`=0 and send 3 bundles → `occupancy`=2, third bundle dropped, `overflow`=1 sticky.
  - Separately, `En` coincident with the last beat at occupancy 2 → accepted, `occupancy` stays 2, `overflow` stays 0.
- **Reset mid-stream.** `rst` at lane 2 of bundle A with bundle B queued → next cycle `pixelValid`=0 and `occupancy`=0. A fresh bundle then streams from lane 0.
